des_key_schedule: RTL and testbench

- Iterative DES key-schedule generator. Accepts one 64-bit key per operation and produces the 16 48-bit round subkeys, one at a time, on a consumer-paced advance handshake.
- Sits directly upstream of the Feistel round stage: round_key_o drives that stage's 48-bit round_key input.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).

---
 rtl/des_key_schedule.sv | 151 +++++++++++++++
 tb/tb_des_key_schedule.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Brief    : Iterative DES key schedule; presents the 16 round subkeys one at
//            a time in encrypt (K1..K16) or decrypt (K16..K1) order.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [63:0] key_i,
  input  logic        decrypt_i,
  input  logic        key_next_i,
  output logic [47:0] round_key_o,
  output logic        round_key_valid_o,
  output logic [3:0]  round_idx_o,
  output logic        last_round_o,
  output logic        key_parity_err_o
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // FIPS 46-3 tables; entries are 1-based bit numbers, bit 1 = MSB.
  localparam int c_pc1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int c_pc2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit r set means round r+1 rotates by two positions instead of one.
  localparam logic [15:0] c_shift2 = 16'h7EFC;

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[64-c_pc1[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[56-c_pc2[i]];
    end
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
    return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_t      r_state;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic [3:0]  r_idx;
  logic        r_dec;
  logic        r_perr;

  logic [55:0] w_cd0;
  logic [27:0] w_c0;
  logic [27:0] w_d0;
  logic [3:0]  w_idx_next;
  logic [3:0]  w_dec_sel;
  logic [7:0]  w_byte_odd;
  logic        w_perr;
  logic        w_accept;
  logic        w_advance;

  assign w_cd0      = pc1(key_i);
  assign w_c0       = w_cd0[55:28];
  assign w_d0       = w_cd0[27:0];
  assign w_idx_next = r_idx + 4'd1;
  // 16 - idx_new, taken modulo 16
  assign w_dec_sel  = 4'd0 - w_idx_next;

  for (genvar b = 0; b < 8; b++) begin : g_byte
    assign w_byte_odd[b] = ^key_i[8*b +: 8];
  end

  assign w_perr    = CHECK_PARITY & ~(&w_byte_odd);
  assign w_accept  = key_valid_i && (r_state == ST_IDLE);
  assign w_advance = key_next_i && (r_state == ST_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_idx   <= '0;
      r_dec   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (w_accept) begin
        // Decrypt starts at K16: total rotation over 16 rounds is 28, i.e. identity.
        r_c     <= decrypt_i ? w_c0 : rotl(w_c0, 1'b0);
        r_d     <= decrypt_i ? w_d0 : rotl(w_d0, 1'b0);
        r_idx   <= '0;
        r_dec   <= decrypt_i;
        r_perr  <= w_perr;
        r_state <= ST_RUN;
      end else if (w_advance) begin
        if (r_idx == 4'd15) begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_c     <= '0;
          r_d     <= '0;
        end else begin
          r_idx <= w_idx_next;
          if (r_dec) begin
            r_c <= rotr(r_c, c_shift2[w_dec_sel]);
            r_d <= rotr(r_d, c_shift2[w_dec_sel]);
          end else begin
            r_c <= rotl(r_c, c_shift2[w_idx_next]);
            r_d <= rotl(r_d, c_shift2[w_idx_next]);
          end
        end
      end
    end
  end

  assign key_ready_o       = (r_state == ST_IDLE);
  assign round_key_valid_o = (r_state == ST_RUN);
  assign round_key_o       = round_key_valid_o ? pc2({r_c, r_d}) : 48'd0;
  assign round_idx_o       = r_idx;
  assign last_round_o      = round_key_valid_o && (r_idx == 4'd15);
  assign key_parity_err_o  = r_perr;

endmodule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule
// Brief    : Randomized self-checking bench against a table-driven DES
//            key-schedule model (cumulative shifts, bit-array permutations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

  localparam logic [63:0] c_key = 64'h133457799BBCDFF1;

  localparam int c_pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int c_pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int c_shift_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid, key_next, decrypt;
  logic [63:0] key;

  logic        p_rdy, p_vld, p_last, p_perr;
  logic [47:0] p_rk;
  logic [3:0]  p_idx;
  logic        n_rdy, n_vld, n_last, n_perr;
  logic [47:0] n_rk;
  logic [3:0]  n_idx;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [47:0] m_ks  [16];
  logic [47:0] obs   [16];
  logic [47:0] enc_obs [16];

  always #5 clk = ~clk;

  des_key_schedule #(.CHECK_PARITY(1'b1)) u_dut_p (
    .clk(clk), .rst(rst), .key_valid_i(key_valid), .key_ready_o(p_rdy),
    .key_i(key), .decrypt_i(decrypt), .key_next_i(key_next),
    .round_key_o(p_rk), .round_key_valid_o(p_vld), .round_idx_o(p_idx),
    .last_round_o(p_last), .key_parity_err_o(p_perr)
  );

  des_key_schedule u_dut_n (
    .clk(clk), .rst(rst), .key_valid_i(key_valid), .key_ready_o(n_rdy),
    .key_i(key), .decrypt_i(decrypt), .key_next_i(key_next),
    .round_key_o(n_rk), .round_key_valid_o(n_vld), .round_idx_o(n_idx),
    .last_round_o(n_last), .key_parity_err_o(n_perr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: all 16 subkeys from the key using cumulative rotation amounts.
  task automatic model_ks(input logic [63:0] k);
    bit kb  [1:64];
    bit cd0 [1:56];
    bit cdr [1:56];
    int cum;
    for (int n = 1; n <= 64; n++) kb[n] = k[64-n];
    for (int i = 1; i <= 56; i++) cd0[i] = kb[c_pc1_t[i-1]];
    cum = 0;
    for (int r = 0; r < 16; r++) begin
      cum += c_shift_t[r];
      for (int j = 0; j < 28; j++) begin
        cdr[j+1]  = cd0[((j + cum) % 28) + 1];
        cdr[j+29] = cd0[((j + cum) % 28) + 29];
      end
      for (int o = 1; o <= 48; o++) m_ks[r][48-o] = cdr[c_pc2_t[o-1]];
    end
  endtask

  function automatic logic model_perr(input logic [63:0] k);
    logic e;
    e = 1'b0;
    for (int b = 0; b < 8; b++) if ($countones(k[8*b +: 8]) % 2 == 0) e = 1'b1;
    return e;
  endfunction

  task automatic check_idle(input logic exp_perr);
    chk("idle_rk_p", 64'(p_rk), 64'd0);
    chk("idle_rk_n", 64'(n_rk), 64'd0);
    chk("idle_idx", 64'(p_idx), 64'd0);
    chk("idle_valid", 64'(p_vld), 64'd0);
    chk("idle_ready", 64'(p_rdy), 64'd1);
    chk("idle_ready_n", 64'(n_rdy), 64'd1);
    chk("idle_last", 64'(p_last), 64'd0);
    chk("idle_perr_p", 64'(p_perr), 64'(exp_perr));
    chk("idle_perr_n", 64'(n_perr), 64'd0);
  endtask

  task automatic check_step(input int i, input logic [47:0] exp, input logic exp_perr);
    chk("rk_p", 64'(p_rk), 64'(exp));
    chk("rk_n", 64'(n_rk), 64'(exp));
    chk("idx", 64'(p_idx), 64'(i));
    chk("idx_n", 64'(n_idx), 64'(i));
    chk("valid", 64'(p_vld), 64'd1);
    chk("ready", 64'(p_rdy), 64'd0);
    chk("last", 64'(p_last), 64'(i == 15));
    chk("last_n", 64'(n_last), 64'(i == 15));
    chk("perr_p", 64'(p_perr), 64'(exp_perr));
    chk("perr_n", 64'(n_perr), 64'd0);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!p_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", 64'(p_rdy), 64'd1);
  endtask

  // mode 0: key_next held; 1: pulse every 3rd cycle + ignored keys; 2: random pacing
  task automatic run_op(input logic [63:0] k, input logic dec, input int mode);
    logic perr_e;
    int   g;
    model_ks(k);
    perr_e = model_perr(k);
    wait_ready();
    key_valid = 1'b1; key = k; decrypt = dec; key_next = 1'b0;
    @(posedge clk); #1;
    key_valid = 1'b0; key = {$urandom, $urandom}; decrypt = 1'($urandom);
    for (int i = 0; i < 16; i++) begin
      g = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
      obs[i] = p_rk;
      for (int s = 0; s <= g; s++) begin
        check_step(i, dec ? m_ks[15-i] : m_ks[i], perr_e);
        key_next  = (s == g);
        key_valid = 1'b0;
        if (s < g && (mode == 1 || $urandom_range(0, 3) == 0)) begin
          key_valid = 1'b1;
          key       = (mode == 1) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
          decrypt   = 1'($urandom);
        end
        @(posedge clk); #1;
      end
    end
    key_next = 1'b0; key_valid = 1'b0;
    check_idle(perr_e);
  endtask

  initial begin
    rst = 1'b1; key_valid = 1'b0; key_next = 1'b0; decrypt = 1'b0; key = '0;
    #2;
    check_idle(1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(c_key, 1'b0, 0);
    chk("enc_k1", 64'(obs[0]), 64'h1B02EFFC7072);
    chk("enc_k2", 64'(obs[1]), 64'h79AED9DBC9E5);
    chk("enc_k16", 64'(obs[15]), 64'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++) enc_obs[i] = obs[i];

    run_op(c_key, 1'b1, 0);
    chk("dec_0", 64'(obs[0]), 64'hCB3D8B0E17F5);
    chk("dec_14", 64'(obs[14]), 64'h79AED9DBC9E5);
    chk("dec_15", 64'(obs[15]), 64'h1B02EFFC7072);
    for (int i = 0; i < 16; i++) chk("dec_rev", 64'(obs[i]), 64'(enc_obs[15-i]));

    run_op(c_key, 1'b0, 1);
    for (int i = 0; i < 16; i++) chk("paced_seq", 64'(obs[i]), 64'(enc_obs[i]));

    run_op(64'd0, 1'b0, 2);
    for (int i = 0; i < 16; i++) chk("zero_key_rk", 64'(obs[i]), 64'd0);

    // Asynchronous reset in the middle of an operation
    wait_ready();
    key_valid = 1'b1; key = c_key; decrypt = 1'b0;
    @(posedge clk); #1;
    key_valid = 1'b0; key_next = 1'b1;
    repeat (7) @(posedge clk);
    #1 key_next = 1'b0;
    chk("pre_rst_idx", 64'(p_idx), 64'd7);
    #3 rst = 1'b1;
    #1 check_idle(1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(c_key, 1'b0, 0);
    chk("post_rst_k1", 64'(obs[0]), 64'h1B02EFFC7072);

    // key_next toggling in IDLE
    for (int i = 0; i < 10; i++) begin
      key_next = ~key_next;
      @(posedge clk); #1;
      chk("idle_nx_valid", 64'(p_vld), 64'd0);
      chk("idle_nx_idx", 64'(p_idx), 64'd0);
    end
    key_next = 1'b0;

    repeat (24) run_op({$urandom, $urandom}, 1'($urandom), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
